// File: rtl/interp_line_reader.sv
`default_nettype none
// ============================================================================
// Module   : interp_line_reader
// Purpose  : Read-side sequencer for the two interpolation line FIFOs.
//            Drains afifo1 (row-interpolated lines) and afifo0
//            (column-interpolated lines) alternately, one full line each,
//            and emits the pixels as an AXI4-Stream video stream with
//            start-of-frame (tuser) and end-of-line (tlast) markers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   aclk                  in   single clock (FIFO read clock)
//   rst_n                 in   asynchronous active-low reset
//   enable                in   run level; low finishes the line then idles
//   afifoX_empty          in   FIFO empty flags
//   afifoX_rd_rst_busy    in   FIFO read-reset busy flags
//   afifoX_out            in   FIFO read data (valid one cycle after rd_en)
//   afifoX_rd_en          out  FIFO read strobes (never both high)
//   m_axis_tdata/tvalid   out  pixel stream
//   m_axis_tready         in   sink ready
//   m_axis_tuser          out  first pixel of frame
//   m_axis_tlast          out  last pixel of line
//   sel                   out  request-side source (0 = afifo1, 1 = afifo0)
//   frame_done            out  one-cycle pulse after the last frame pixel
// ============================================================================
module interp_line_reader #(
  parameter int dataWidth   = 8,
  parameter int LINE_WIDTH  = 1280,
  parameter int FRAME_LINES = 720
) (
  input  logic                 aclk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 afifo0_empty,
  input  logic                 afifo1_empty,
  input  logic                 afifo0_rd_rst_busy,
  input  logic                 afifo1_rd_rst_busy,
  input  logic [dataWidth-1:0] afifo0_out,
  input  logic [dataWidth-1:0] afifo1_out,
  output logic                 afifo0_rd_en,
  output logic                 afifo1_rd_en,
  output logic [dataWidth-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 sel,
  output logic                 frame_done
);

  localparam int            CW          = 12;
  localparam logic [CW-1:0] c_PIX_LAST  = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0] c_LINE_LAST = CW'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    S_WAIT_RST = 2'd0,
    S_IDLE     = 2'd1,
    S_LINE     = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_sel;          // request-side source
  logic                 r_req_run;      // request side may issue reads
  logic                 r_inflight;     // a read was issued last cycle
  logic                 r_inflight_sel; // source of that read
  logic [CW-1:0]        r_req_cnt;
  logic [CW-1:0]        r_out_cnt;
  logic [CW-1:0]        r_line_cnt;
  logic [1:0]           r_occ;          // output buffer occupancy (0..2)
  logic [dataWidth-1:0] r_buf0;         // buffer head
  logic [dataWidth-1:0] r_buf1;
  logic                 r_frame_done;

  logic                 w_busy;
  logic                 w_sel_empty;
  logic                 w_pop;
  logic [2:0]           w_level;
  logic                 w_rd;
  logic [dataWidth-1:0] w_cap_data;
  logic                 w_last_beat;
  logic                 w_req_last;

  assign w_busy      = afifo0_rd_rst_busy | afifo1_rd_rst_busy;
  assign w_sel_empty = r_sel ? afifo0_empty : afifo1_empty;
  assign w_pop       = (r_occ != 2'd0) & m_axis_tready;
  // Buffer slots committed after this cycle's pop; never exceeds 2.
  assign w_level     = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  // req_cnt wraps when the last read of a line is issued, so it is always
  // below LINE_WIDTH here and needs no explicit bound check.
  assign w_rd        = (r_state == S_LINE) & r_req_run & ~w_busy &
                       ~w_sel_empty & (w_level < 3'd2);
  assign w_cap_data  = r_inflight_sel ? afifo0_out : afifo1_out;
  // Tags follow the head entry: out_cnt only moves on acceptance, so it is
  // always the beat index of the head and stays stable under backpressure.
  assign w_last_beat = (r_out_cnt == c_PIX_LAST);
  assign w_req_last  = (r_req_cnt == c_PIX_LAST);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_WAIT_RST;
      r_sel          <= 1'b0;
      r_req_run      <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_sel <= 1'b0;
      r_req_cnt      <= '0;
      r_out_cnt      <= '0;
      r_line_cnt     <= '0;
      r_occ          <= 2'd0;
      r_buf0         <= '0;
      r_buf1         <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if ((r_state != S_WAIT_RST) && w_busy) begin
        // FIFO went into reset: drop everything, including the read in flight.
        r_state    <= S_WAIT_RST;
        r_sel      <= 1'b0;
        r_req_run  <= 1'b0;
        r_inflight <= 1'b0;
        r_req_cnt  <= '0;
        r_out_cnt  <= '0;
        r_line_cnt <= '0;
        r_occ      <= 2'd0;
      end else begin
        case (r_state)
          S_WAIT_RST: if (!w_busy) r_state <= S_IDLE;
          S_IDLE: begin
            if (enable) begin
              r_state   <= S_LINE;
              r_req_run <= 1'b1;
            end
          end
          S_LINE:  ;
          default: r_state <= S_WAIT_RST;
        endcase

        // Request side runs ahead of the output side: it switches source as
        // soon as the last read of a line is issued, which keeps the line
        // boundary bubble-free. It only starts the next line if still enabled.
        r_inflight <= w_rd;
        if (w_rd) begin
          r_inflight_sel <= r_sel;
          if (w_req_last) begin
            r_req_cnt <= '0;
            r_sel     <= ~r_sel;
            r_req_run <= enable;
          end else begin
            r_req_cnt <= r_req_cnt + 1'b1;
          end
        end

        // Two-entry buffer, head in r_buf0.
        case ({w_pop, r_inflight})
          2'b01: begin
            if (r_occ == 2'd0) r_buf0 <= w_cap_data;
            else               r_buf1 <= w_cap_data;
            r_occ <= r_occ + 2'd1;
          end
          2'b10: begin
            r_buf0 <= r_buf1;
            r_occ  <= r_occ - 2'd1;
          end
          2'b11: begin
            if (r_occ == 2'd1) begin
              r_buf0 <= w_cap_data;
            end else begin
              r_buf0 <= r_buf1;
              r_buf1 <= w_cap_data;
            end
          end
          default: ;
        endcase

        // Output side: beat/line accounting on acceptance.
        if (w_pop) begin
          if (w_last_beat) begin
            r_out_cnt <= '0;
            if (r_line_cnt == c_LINE_LAST) begin
              r_line_cnt   <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_line_cnt <= r_line_cnt + 1'b1;
            end
            // Request side stopped at the end of this line: either resume
            // straight away or park in IDLE.
            if (!r_req_run) begin
              if (enable) r_req_run <= 1'b1;
              else        r_state   <= S_IDLE;
            end
          end else begin
            r_out_cnt <= r_out_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign afifo0_rd_en  = w_rd & r_sel;
  assign afifo1_rd_en  = w_rd & ~r_sel;
  assign m_axis_tvalid = (r_occ != 2'd0);
  assign m_axis_tdata  = r_buf0;
  assign m_axis_tlast  = m_axis_tvalid & w_last_beat;
  assign m_axis_tuser  = m_axis_tvalid & (r_out_cnt == '0) & (r_line_cnt == '0);
  assign sel           = r_sel;
  assign frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_interp_line_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_interp_line_reader
// Purpose  : Self-checking bench for interp_line_reader. Models both line
//            FIFOs, predicts the output stream as alternating whole lines
//            (afifo1 on even lines, afifo0 on odd lines) and checks every
//            valid beat, tags, frame_done and read-strobe rules each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interp_line_reader;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int FL = 2;

  typedef logic [DW-1:0] pix_t;

  logic aclk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic afifo0_empty = 1'b1;
  logic afifo1_empty = 1'b1;
  logic afifo0_rd_rst_busy = 1'b0;
  logic afifo1_rd_rst_busy = 1'b0;
  pix_t afifo0_out = '0;
  pix_t afifo1_out = '0;
  logic afifo0_rd_en, afifo1_rd_en;
  pix_t m_axis_tdata;
  logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, sel, frame_done;
  logic m_axis_tready = 1'b1;

  interp_line_reader #(
    .dataWidth  (DW),
    .LINE_WIDTH (LW),
    .FRAME_LINES(FL)
  ) dut (
    .aclk              (aclk),
    .rst_n             (rst_n),
    .enable            (enable),
    .afifo0_empty      (afifo0_empty),
    .afifo1_empty      (afifo1_empty),
    .afifo0_rd_rst_busy(afifo0_rd_rst_busy),
    .afifo1_rd_rst_busy(afifo1_rd_rst_busy),
    .afifo0_out        (afifo0_out),
    .afifo1_out        (afifo1_out),
    .afifo0_rd_en      (afifo0_rd_en),
    .afifo1_rd_en      (afifo1_rd_en),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tlast      (m_axis_tlast),
    .sel               (sel),
    .frame_done        (frame_done)
  );

  always #5 aclk = ~aclk;

  // FIFO contents (q*) and expected delivery order (e*)
  pix_t q0[$], q1[$], e0[$], e1[$];
  bit   pend0 = 1'b0, pend1 = 1'b0;
  bit   bp_mode = 1'b0;
  int   ecyc = 0;

  // model state
  int m_line = 0, m_pix = 0;
  bit exp_fd = 1'b0;
  int acc_total = 0, rd_total = 0, fd_cnt = 0;
  int log_d[$], log_u[$], log_l[$], log_c[$];
  int ncyc = 0;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ok(input string name, input bit ok, input int act, input int lim);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d limit %0d", name, act, lim);
    end
  endtask

  task automatic push0(input int v);
    q0.push_back(pix_t'(v));
    e0.push_back(pix_t'(v));
  endtask

  task automatic push1(input int v);
    q1.push_back(pix_t'(v));
    e1.push_back(pix_t'(v));
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k;
    k = 0;
    while (acc_total < n && k < budget) begin
      @(posedge aclk);
      k++;
    end
    #2;
    check_ok("wait_acc_timeout", acc_total >= n, acc_total, n);
  endtask

  // FIFO read-port model (standard mode) and tready driver
  always @(posedge aclk) begin
    #1;
    ecyc++;
    if (pend0 && q0.size() != 0) afifo0_out = q0.pop_front();
    if (pend1 && q1.size() != 0) afifo1_out = q1.pop_front();
    afifo0_empty = (q0.size() == 0);
    afifo1_empty = (q1.size() == 0);
    if (bp_mode) m_axis_tready = ((ecyc % 4) == 0) || ((ecyc % 4) == 3);
    else         m_axis_tready = 1'b1;
  end

  // Per-cycle comparison against the line-alternation model
  always @(negedge aclk) begin : p_cmp
    int  expd;
    bit  have;
    pend0 = afifo0_rd_en;
    pend1 = afifo1_rd_en;
    if (rst_n) begin
      ncyc++;
      check("frame_done", int'(frame_done), int'(exp_fd));
      if (frame_done) fd_cnt++;
      exp_fd = 1'b0;
      check_ok("rd_en_exclusive", !(afifo0_rd_en && afifo1_rd_en),
               int'(afifo0_rd_en) + int'(afifo1_rd_en), 1);
      if (afifo0_rd_en) check_ok("rd0_when_empty", !afifo0_empty, 1, 0);
      if (afifo1_rd_en) check_ok("rd1_when_empty", !afifo1_empty, 1, 0);
      rd_total += int'(afifo0_rd_en) + int'(afifo1_rd_en);
      if (m_axis_tvalid) begin
        have = (m_line % 2 == 0) ? (e1.size() != 0) : (e0.size() != 0);
        check_ok("unexpected_beat", have, int'(m_axis_tdata), -1);
        if (have) begin
          expd = (m_line % 2 == 0) ? int'(e1[0]) : int'(e0[0]);
          check("tdata", int'(m_axis_tdata), expd);
          check("tuser", int'(m_axis_tuser), int'(m_pix == 0 && m_line == 0));
          check("tlast", int'(m_axis_tlast), int'(m_pix == LW - 1));
          if (m_axis_tready) begin
            if (m_line % 2 == 0) void'(e1.pop_front());
            else                 void'(e0.pop_front());
            acc_total++;
            log_d.push_back(int'(m_axis_tdata));
            log_u.push_back(int'(m_axis_tuser));
            log_l.push_back(int'(m_axis_tlast));
            log_c.push_back(ncyc);
            if (m_pix == LW - 1) begin
              m_pix = 0;
              if (m_line == FL - 1) begin
                m_line = 0;
                exp_fd = 1'b1;
              end else begin
                m_line++;
              end
            end else begin
              m_pix++;
            end
          end
        end
      end
      check_ok("outstanding", (rd_total - acc_total) <= 2, rd_total - acc_total, 2);
    end
  end

  initial begin : p_main
    int rs, lb;
    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    check("rst_tvalid", int'(m_axis_tvalid), 0);
    check("rst_rd_en0", int'(afifo0_rd_en), 0);
    check("rst_rd_en1", int'(afifo1_rd_en), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_tdata", int'(m_axis_tdata), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_sel", int'(sel), 0);
    check("idle_no_rd", int'(afifo1_rd_en), 0);

    // ---- nominal frame ----
    for (int v = 1; v <= 4; v++) push1(v);
    for (int v = 5; v <= 8; v++) push0(v);
    tick();
    tick();
    enable = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    check("first_beat_not_early", int'(m_axis_tvalid), 0);
    @(negedge aclk);
    #1;
    check("first_beat_valid", int'(m_axis_tvalid), 1);
    check("first_beat_data", int'(m_axis_tdata), 1);
    check("first_beat_tuser", int'(m_axis_tuser), 1);
    wait_acc(8, 50);
    repeat (3) tick();
    check("nominal_fd_count", fd_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      check("nominal_data", log_d[i], i + 1);
      check("nominal_spacing", log_c[i] - log_c[0], i);
      check("nominal_tlast", log_l[i], int'(i == 3 || i == 7));
      check("nominal_tuser", log_u[i], int'(i == 0));
    end

    // ---- backpressure ----
    bp_mode = 1'b1;
    for (int v = 11; v <= 14; v++) push1(v);
    for (int v = 15; v <= 18; v++) push0(v);
    wait_acc(16, 200);
    bp_mode = 1'b0;
    for (int i = 8; i < 16; i++) check("bp_data", log_d[i], i + 3);

    // ---- mid-line underflow ----
    push1(21);
    push1(22);
    wait_acc(18, 50);
    repeat (8) tick();
    check("underflow_tvalid", int'(m_axis_tvalid), 0);
    check("underflow_count", acc_total, 18);
    push1(23);
    push1(24);
    for (int v = 25; v <= 28; v++) push0(v);
    wait_acc(24, 80);
    check("underflow_last_data", log_d[19], 24);
    check("underflow_last_tlast", log_l[19], 1);

    // ---- enable low mid-line ----
    push1(31);
    push1(32);
    wait_acc(26, 50);
    enable = 1'b0;
    push1(33);
    push1(34);
    wait_acc(28, 50);
    check("stop_line_tlast", log_l[27], 1);
    repeat (4) tick();
    rs = rd_total;
    for (int v = 41; v <= 44; v++) push0(v);
    for (int v = 51; v <= 54; v++) push1(v);
    repeat (10) tick();
    check("stopped_no_reads", rd_total, rs);
    check("stopped_sel", int'(sel), 1);
    check("stopped_tvalid", int'(m_axis_tvalid), 0);
    enable = 1'b1;
    wait_acc(36, 80);
    check("resume_data", log_d[28], 41);
    check("resume_tuser", log_u[28], 0);
    check("next_frame_data", log_d[32], 51);
    check("next_frame_tuser", log_u[32], 1);

    // ---- reset mid-line, then FIFO read-reset busy ----
    for (int v = 71; v <= 74; v++) push0(v);
    wait_acc(38, 50);
    @(posedge aclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", int'(m_axis_tvalid), 0);
    check("async_rst_rd_en0", int'(afifo0_rd_en), 0);
    check("async_rst_sel", int'(sel), 0);
    check("async_rst_tdata", int'(m_axis_tdata), 0);
    q0.delete();
    q1.delete();
    e0.delete();
    e1.delete();
    m_line = 0;
    m_pix = 0;
    exp_fd = 1'b0;
    acc_total = 0;
    rd_total = 0;
    lb = log_d.size();
    afifo0_rd_rst_busy = 1'b1;
    afifo1_rd_rst_busy = 1'b1;
    for (int v = 81; v <= 84; v++) push1(v);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("busy_no_reads", rd_total, 0);
    check("busy_tvalid", int'(m_axis_tvalid), 0);
    afifo0_rd_rst_busy = 1'b0;
    afifo1_rd_rst_busy = 1'b0;
    wait_acc(4, 40);
    check("post_reset_data", log_d[lb], 81);
    check("post_reset_tuser", log_u[lb], 1);
    check("post_reset_tlast", log_l[lb + 3], 1);
    repeat (3) tick();
    check("all_delivered", int'(e0.size()) + int'(e1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
